// File: rtl/ann_window_feeder.sv
// rtl/ann_window_feeder.sv - 4-day sliding-window sequencer for the ANN Tmax predictor (option macro: FEEDER_MISSING_SUB_EN)
module ann_window_feeder #(
  parameter int DATA_W       = 156,
  parameter int NUM_DAYS     = 369,
  parameter int START_CYCLES = 5,
  parameter int TIMEOUT      = 255
) (
  input  logic              Clk,
  input  logic              Reset_h,
  input  logic [DATA_W-1:0] Sample_in,
  input  logic              Sample_valid_h,
  input  logic              Sample_missing_h,
  output logic              Sample_ready_h,
  output logic [DATA_W-1:0] Ann_temp_0,
  output logic [DATA_W-1:0] Ann_temp_1,
  output logic [DATA_W-1:0] Ann_temp_2,
  output logic [DATA_W-1:0] Ann_temp_3,
  output logic              Ann_start_h,
  input  logic [DATA_W-1:0] Ann_data_out,
  input  logic              Ann_ready_h,
  output logic [DATA_W-1:0] Pred_out,
  output logic              Pred_valid_h,
  output logic [15:0]       Pred_index,
  output logic              Done_h,
  output logic              Err_h
);

  localparam logic [2:0] S_FILL        = 3'd0;
  localparam logic [2:0] S_START       = 3'd1;
  localparam logic [2:0] S_WAIT_RDY    = 3'd2;
  localparam logic [2:0] S_CAPTURE     = 3'd3;
  localparam logic [2:0] S_WAIT_SAMPLE = 3'd4;
  localparam logic [2:0] S_DONE        = 3'd5;

  localparam logic [15:0] PRED_TOTAL  = 16'(NUM_DAYS - 4);
  localparam logic [15:0] START_LAST  = 16'(START_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_END = 16'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [2:0]        fill_cnt;
  logic [15:0]       cyc_cnt;
  logic [15:0]       win_index;
  logic [15:0]       pred_count;
  logic              xfer;
  logic              sample_bad;
  logic              shift_err;
  logic [DATA_W-1:0] shift_data;
  logic              rdy_timeout;
  logic [25:0]       scaled;
  logic              unused_data_hi;

  assign xfer           = Sample_valid_h & Sample_ready_h;
  assign scaled         = Ann_data_out[25:0] / 26'd1000;
  assign unused_data_hi = ^Ann_data_out[DATA_W-1:26];
  assign rdy_timeout    = (state == S_WAIT_RDY) && !Ann_ready_h && (cyc_cnt == TIMEOUT_END);

  // A sample counts as missing when flagged, or when it carries X/Z in simulation
  always_comb begin
    sample_bad = Sample_missing_h;
`ifndef SYNTHESIS
    if ($isunknown(Sample_in)) sample_bad = 1'b1;
`endif
  end

  // Pick the value entering the window: the sample, or a substitute for a missing day
  always_comb begin
    shift_data = Sample_in;
    shift_err  = 1'b0;
    if (sample_bad) begin
      if (state == S_WAIT_SAMPLE) begin
`ifdef FEEDER_MISSING_SUB_EN
        shift_data = Pred_out;
`else
        shift_data = '0;
        shift_err  = 1'b1;
`endif
      end else begin
        // No prediction exists yet while filling, so zero is the only stand-in
        shift_data = '0;
        shift_err  = 1'b1;
      end
    end
  end

  // Next-state decode; ready beats timeout when both land on the same cycle
  always_comb begin
    next_state = state;
    case (state)
      S_FILL: begin
        if (xfer && (fill_cnt == 3'd3)) next_state = S_START;
      end
      S_START: begin
        if (cyc_cnt == START_LAST) next_state = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (Ann_ready_h)      next_state = S_CAPTURE;
        else if (rdy_timeout) next_state = S_WAIT_SAMPLE;
      end
      S_CAPTURE: begin
        if (pred_count + 16'd1 == PRED_TOTAL) next_state = S_DONE;
        else                                  next_state = S_WAIT_SAMPLE;
      end
      S_WAIT_SAMPLE: begin
        if (xfer) next_state = S_START;
      end
      S_DONE: begin
        next_state = S_DONE;
      end
      default: next_state = S_FILL;
    endcase
  end

  // State register plus the fill, cycle, window-day and issued-prediction counters
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state      <= S_FILL;
      fill_cnt   <= 3'd0;
      cyc_cnt    <= 16'd0;
      win_index  <= 16'd0;
      pred_count <= 16'd0;
    end else begin
      state <= next_state;
      if (next_state != state) cyc_cnt <= 16'd0;
      else                     cyc_cnt <= cyc_cnt + 16'd1;
      if ((state == S_FILL) && xfer)        fill_cnt  <= fill_cnt + 3'd1;
      if ((state == S_WAIT_SAMPLE) && xfer) win_index <= win_index + 16'd1;
      if (state == S_CAPTURE)               pred_count <= pred_count + 16'd1;
    end
  end

  // Window shift register: newest sample enters at Ann_temp_3
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      Ann_temp_0 <= '0;
      Ann_temp_1 <= '0;
      Ann_temp_2 <= '0;
      Ann_temp_3 <= '0;
    end else if (xfer) begin
      Ann_temp_0 <= Ann_temp_1;
      Ann_temp_1 <= Ann_temp_2;
      Ann_temp_2 <= Ann_temp_3;
      Ann_temp_3 <= shift_data;
    end
  end

  // Handshake and strobe outputs, registered from the next state so they track it exactly
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      Sample_ready_h <= 1'b0;
      Ann_start_h    <= 1'b0;
      Pred_valid_h   <= 1'b0;
      Done_h         <= 1'b0;
    end else begin
      Sample_ready_h <= (next_state == S_FILL) || (next_state == S_WAIT_SAMPLE);
      Ann_start_h    <= (next_state == S_START);
      Pred_valid_h   <= (next_state == S_CAPTURE);
      Done_h         <= Done_h || (next_state == S_DONE);
    end
  end

  // Capture and scale the ANN result; Pred_index reports the day of the window that produced it
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      Pred_out   <= '0;
      Pred_index <= 16'd0;
    end else if ((state == S_WAIT_RDY) && Ann_ready_h) begin
      Pred_out   <= {{(DATA_W-26){1'b0}}, scaled};
      Pred_index <= win_index;
    end
  end

  // Sticky error: missing sample with no substitute, or the ANN never answered
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      Err_h <= 1'b0;
    end else if ((xfer && shift_err) || rdy_timeout) begin
      Err_h <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ann_window_feeder.sv
// tb/tb_ann_window_feeder.sv - directed table-driven bench for ann_window_feeder
module tb_ann_window_feeder;
  localparam int DW = 156;

`ifdef FEEDER_MISSING_SUB_EN
  localparam logic [DW-1:0] MISS_VAL = 156'h19;
  localparam logic          MISS_ERR = 1'b0;
`else
  localparam logic [DW-1:0] MISS_VAL = 156'h0;
  localparam logic          MISS_ERR = 1'b1;
`endif

  logic          Clk = 1'b0;
  logic          Reset_h;
  logic [DW-1:0] Sample_in;
  logic          Sample_valid_h;
  logic          Sample_missing_h;
  logic          Sample_ready_h;
  logic [DW-1:0] Ann_temp_0, Ann_temp_1, Ann_temp_2, Ann_temp_3;
  logic          Ann_start_h;
  logic [DW-1:0] Ann_data_out;
  logic          Ann_ready_h;
  logic [DW-1:0] Pred_out;
  logic          Pred_valid_h;
  logic [15:0]   Pred_index;
  logic          Done_h;
  logic          Err_h;

  int tests = 0;
  int fails = 0;

  ann_window_feeder #(.DATA_W(DW), .NUM_DAYS(8), .START_CYCLES(5), .TIMEOUT(255)) dut (
    .Clk(Clk), .Reset_h(Reset_h),
    .Sample_in(Sample_in), .Sample_valid_h(Sample_valid_h), .Sample_missing_h(Sample_missing_h),
    .Sample_ready_h(Sample_ready_h),
    .Ann_temp_0(Ann_temp_0), .Ann_temp_1(Ann_temp_1), .Ann_temp_2(Ann_temp_2), .Ann_temp_3(Ann_temp_3),
    .Ann_start_h(Ann_start_h), .Ann_data_out(Ann_data_out), .Ann_ready_h(Ann_ready_h),
    .Pred_out(Pred_out), .Pred_valid_h(Pred_valid_h), .Pred_index(Pred_index),
    .Done_h(Done_h), .Err_h(Err_h)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [DW-1:0] sample;
    logic          missing;
    logic [DW-1:0] ann;
    logic [DW-1:0] t0, t1, t2, t3;
    logic          err;
    logic [DW-1:0] pred;
    logic [15:0]   idx;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one sample and return just after the edge that transfers it
  task automatic send_sample(input logic [DW-1:0] d, input logic miss);
    int n;
    @(negedge Clk);
    Sample_in        = d;
    Sample_missing_h = miss;
    Sample_valid_h   = 1'b1;
    n = 0;
    while (!Sample_ready_h && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL sample_ready_wait: got 0 expected 1 within 50 cycles");
    end
    @(posedge Clk);
    #1;
    Sample_valid_h   = 1'b0;
    Sample_missing_h = 1'b0;
  endtask

  // Count consecutive negedges with Ann_start_h high, ending at the first low one
  task automatic count_start(output int n);
    n = 0;
    @(negedge Clk);
    while (Ann_start_h && n < 20) begin
      n++;
      @(negedge Clk);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_h = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset_h = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int pv;
    logic [DW-1:0] all_ones;
    all_ones = '1;

    tbl[0] = '{sample: 156'h0,  missing: 1'b0, ann: 156'd25000,
               t0: 156'h1A, t1: 156'h1B, t2: 156'h1C, t3: 156'h1D, err: 1'b0, pred: 156'd25, idx: 16'd0};
    tbl[1] = '{sample: 156'hAA, missing: 1'b1, ann: 156'd999,
               t0: 156'h1B, t1: 156'h1C, t2: 156'h1D, t3: MISS_VAL, err: MISS_ERR, pred: 156'd0, idx: 16'd1};
    tbl[2] = '{sample: 156'h55, missing: 1'b0, ann: all_ones,
               t0: 156'h1C, t1: 156'h1D, t2: MISS_VAL, t3: 156'h55, err: MISS_ERR, pred: 156'd67108, idx: 16'd2};
    tbl[3] = '{sample: 156'h77, missing: 1'b0, ann: 156'd1000,
               t0: 156'h1D, t1: MISS_VAL, t2: 156'h55, t3: 156'h77, err: MISS_ERR, pred: 156'd1, idx: 16'd3};

    Reset_h = 1'b1; Sample_in = '0; Sample_valid_h = 1'b0; Sample_missing_h = 1'b0;
    Ann_data_out = '0; Ann_ready_h = 1'b0;

    // Reset state
    @(negedge Clk);
    @(negedge Clk);
    check("rst_ready", DW'(Sample_ready_h), 0);
    check("rst_start", DW'(Ann_start_h), 0);
    check("rst_pvalid", DW'(Pred_valid_h), 0);
    check("rst_done", DW'(Done_h), 0);
    check("rst_err", DW'(Err_h), 0);
    check("rst_t3", Ann_temp_3, 0);
    check("rst_pred", Pred_out, 0);
    Reset_h = 1'b0;
    @(negedge Clk);
    check("ready_after_rst", DW'(Sample_ready_h), 1);

    // Full run of NUM_DAYS=8: fill, then four predictions from the table
    send_sample(156'h1A, 1'b0);
    send_sample(156'h1B, 1'b0);
    send_sample(156'h1C, 1'b0);
    send_sample(156'h1D, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) send_sample(tbl[i].sample, tbl[i].missing);
      count_start(n);
      check($sformatf("start_len[%0d]", i), DW'(n), 5);
      check($sformatf("t0[%0d]", i), Ann_temp_0, tbl[i].t0);
      check($sformatf("t1[%0d]", i), Ann_temp_1, tbl[i].t1);
      check($sformatf("t2[%0d]", i), Ann_temp_2, tbl[i].t2);
      check($sformatf("t3[%0d]", i), Ann_temp_3, tbl[i].t3);
      check($sformatf("err[%0d]", i), DW'(Err_h), DW'(tbl[i].err));
      Ann_data_out = tbl[i].ann;
      Ann_ready_h  = 1'b1;
      @(negedge Clk);
      Ann_ready_h  = 1'b0;
      check($sformatf("pvalid[%0d]", i), DW'(Pred_valid_h), 1);
      check($sformatf("pred[%0d]", i), Pred_out, tbl[i].pred);
      check($sformatf("pidx[%0d]", i), DW'(Pred_index), DW'(tbl[i].idx));
      @(negedge Clk);
      check($sformatf("pvalid_off[%0d]", i), DW'(Pred_valid_h), 0);
    end
    check("done", DW'(Done_h), 1);
    check("done_ready", DW'(Sample_ready_h), 0);

    // Samples offered in DONE are not consumed
    Sample_in = 156'hEE; Sample_valid_h = 1'b1;
    repeat (3) @(negedge Clk);
    Sample_valid_h = 1'b0;
    check("done_t3_hold", Ann_temp_3, 156'h77);
    check("done_sticky", DW'(Done_h), 1);

    // Timeout: ANN never answers
    do_reset();
    @(negedge Clk);
    check("rst_clears_done", DW'(Done_h), 0);
    check("rst_clears_err", DW'(Err_h), 0);
    send_sample(156'h01, 1'b0);
    send_sample(156'h02, 1'b0);
    send_sample(156'h03, 1'b0);
    send_sample(156'h04, 1'b0);
    count_start(n);
    check("to_start_len", DW'(n), 5);
    n = 0; pv = 0;
    while (!Sample_ready_h && n < 400) begin
      if (n == 254) check("to_err_early", DW'(Err_h), 0);
      @(negedge Clk);
      n++;
      if (Pred_valid_h) pv++;
    end
    check("to_cycles", DW'(n), 255);
    check("to_err", DW'(Err_h), 1);
    check("to_no_pred", DW'(pv), 0);
    check("to_ready", DW'(Sample_ready_h), 1);

    // Reset pulsed during START aborts at once
    do_reset();
    send_sample(156'h11, 1'b0);
    send_sample(156'h12, 1'b0);
    send_sample(156'h13, 1'b1);
    send_sample(156'h14, 1'b0);
    @(negedge Clk);
    check("mr_start", DW'(Ann_start_h), 1);
    check("mr_fill_missing_err", DW'(Err_h), 1);
    check("mr_fill_missing_t2", Ann_temp_2, 0);
    Reset_h = 1'b1;
    @(negedge Clk);
    Reset_h = 1'b0;
    check("mr_start_off", DW'(Ann_start_h), 0);
    check("mr_err", DW'(Err_h), 0);
    check("mr_t3", Ann_temp_3, 0);
    check("mr_ready", DW'(Sample_ready_h), 0);
    @(negedge Clk);
    check("mr_fill_ready", DW'(Sample_ready_h), 1);
    repeat (10) @(negedge Clk);
    check("mr_no_start", DW'(Ann_start_h), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
